chunked_add_sub_unit: RTL and testbench
=======================================

# chunked_add_sub_unit

Parametrised, multi-cycle integer add/subtract unit for the LEGv8 datapath. It generalises the fixed 64-bit two's-complement subtractor to any width and supports ADD, SUB, ADC and SBC. Optional NZCV flag generation follows LEGv8 ADDS/SUBS semantics. The carry chain is processed CHUNK bits per cycle behind a valid/ready handshake, so wide operands can be traded for cycle time without changing the ALU interface.

## Interface
- WIDTH, 64, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 16, bits added per BUSY cycle; 1 ≤ CHUNK ≤ WIDTH. NCHUNK = WIDTH/CHUNK.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request.
- op  input  2  00 ADD (a+b), 01 SUB (a+~b+1), 10 ADC (a+b+carry_in), 11 SBC (a+~b+carry_in).
- carry_in  input  1  carry for ADC/SBC; ignored for ADD/SUB.
- set_flags  input  1  1 = compute and publish NZCV (ADDS/SUBS forms).
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference, modulo 2^WIDTH.
- nzcv  output  4  {N,Z,C,V}; meaningful only when flags_valid=1.
- flags_valid  output  1  high with out_valid when the op had set_flags=1.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid=1, the edge latches a, b_eff (b or ~b), initial carry (0 ADD, 1 SUB, carry_in ADC/SBC) and set_flags. Chunk counter clears to 0; go to BUSY.
- BUSY: each cycle adds chunk k of a, chunk k of b_eff and the registered carry. The sum is written to result bits [k*CHUNK +: CHUNK] and the carry register is updated.
  - After chunk NCHUNK-1, go to DONE.
  - Operand and op input changes after acceptance are ignored.
- DONE: out_valid=1; result and nzcv are held stable. When out_ready=1 the edge returns to IDLE. No new request is accepted in that cycle.
- Flags, computed at the final chunk:
  - N = result[WIDTH-1].
  - Z = (result == 0) over the full width.
  - C = final carry out. For SUB, C=1 means no borrow (a ≥ b unsigned).
  - V = (a[MSB] == b_eff[MSB]) && (result[MSB] != a[MSB]).
- flags_valid = out_valid && latched set_flags. nzcv is driven to 0 when set_flags=0.
- in_ready=0 in BUSY and DONE; there is no overlap of operations.

## Timing
- Reset, asynchronous on reset_n low: state=IDLE, in_ready=1, out_valid=0, flags_valid=0, result=0, nzcv=0, internal carry and counter = 0.
- Reset mid-BUSY or mid-DONE aborts the operation; the result is discarded and no out_valid is produced.
- Latency: a request accepted on edge T gives out_valid=1 in the cycle after edge T+NCHUNK. That is NCHUNK BUSY cycles; with CHUNK=WIDTH this is one BUSY cycle.
- Throughput: one operation per NCHUNK+2 cycles when out_ready is held at 1.
- Backpressure: out_valid, result, nzcv and flags_valid stay constant for any number of cycles with out_ready=0.
- The carry crosses chunk boundaries only through the registered carry. The combinational path is CHUNK bits.
- All outputs are registered or decoded directly from the state register.

## Test plan
- WIDTH=64, CHUNK=16, SUB a=5 b=3 set_flags=1 -> result=2, nzcv=0010 (C=1), out_valid exactly 4 BUSY cycles after accept.
- SUB a=3 b=5 set_flags=1 -> result=0xFFFF_FFFF_FFFF_FFFE, nzcv=1000 (N=1, C=0 borrow, V=0).
- ADD a=0xFFFF_FFFF_FFFF_FFFF b=1 set_flags=1 -> result=0, nzcv=0110; carry ripples through all 4 chunks.
- ADD a=0x7FFF_FFFF_FFFF_FFFF b=1 -> result=0x8000_0000_0000_0000, nzcv=1001.
- SBC a=10 b=3 carry_in=0 -> 6; ADC a=10 b=3 carry_in=1 -> 14.
- SUB with set_flags=0 -> flags_valid=0, nzcv=0.
- Hold out_ready=0 for 10 cycles -> outputs stable and in_ready=0 throughout; pulsing in_valid during BUSY has no effect.
- Assert reset_n=0 in the 2nd BUSY cycle -> outputs return to reset values immediately; the next request after release completes normally.
- Repeat the first scenario with CHUNK=64 and CHUNK=8 -> identical results, with BUSY lasting 1 and 8 cycles respectively.

Source files
------------

// File: rtl/chunked_add_sub_unit.sv
// Multi-cycle add/subtract for the LEGv8 datapath: ADD/SUB/ADC/SBC with
// optional NZCV, carry rippled CHUNK bits per cycle behind valid/ready.
module chunked_add_sub_unit #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic             carry_in,
  input  logic             set_flags,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       nzcv,
  output logic             flags_valid
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             sf_q, sf_d;
  logic             zero_q, zero_d;
  logic [3:0]       nzcv_q, nzcv_d;

  int               base;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK:0]   sum;
  logic             sum_z;
  logic             ovf;

  // Only CHUNK bits of carry chain per cycle; the rest goes via carry_q.
  always_comb begin
    base  = int'(cnt_q) * CHUNK;
    a_ch  = a_q[base +: CHUNK];
    b_ch  = b_q[base +: CHUNK];
    sum   = {1'b0, a_ch} + {1'b0, b_ch}
          + {{CHUNK{1'b0}}, carry_q};
    sum_z = ~|sum[CHUNK-1:0];
    ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1])
          && (sum[CHUNK-1] != a_q[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    sf_d    = sf_q;
    zero_d  = zero_q;
    nzcv_d  = nzcv_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = op[0] ? ~b : b;
          carry_d = op[1] ? carry_in : op[0];
          sf_d    = set_flags;
          cnt_d   = '0;
          zero_d  = 1'b1;
          nzcv_d  = 4'b0000;
          state_d = BUSY;
        end
      end
      BUSY: begin
        res_d[base +: CHUNK] = sum[CHUNK-1:0];
        carry_d = sum[CHUNK];
        zero_d  = zero_q & sum_z;
        if (cnt_q == LAST) begin
          state_d = DONE;
          if (sf_q) begin
            nzcv_d = {sum[CHUNK-1], zero_q & sum_z,
                      sum[CHUNK], ovf};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      sf_q    <= 1'b0;
      zero_q  <= 1'b0;
      nzcv_q  <= 4'b0000;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      sf_q    <= sf_d;
      zero_q  <= zero_d;
      nzcv_q  <= nzcv_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign flags_valid = (state_q == DONE) && sf_q;
  assign result      = res_q;
  assign nzcv        = nzcv_q;

endmodule

// File: tb/tb_chunked_add_sub_unit.sv
// Directed bench for chunked_add_sub_unit at CHUNK = 16, 64 and 8.
// Index 0 is CHUNK=16, 1 is CHUNK=64, 2 is CHUNK=8.
module tb_chunked_add_sub_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  iv;
  logic [2:0]  irdy;
  logic [2:0]  ov;
  logic [2:0]  ordy;
  logic [2:0]  fv;
  logic [1:0]  op;
  logic        carry_in;
  logic        set_flags;
  logic [63:0] a;
  logic [63:0] b;
  logic [63:0] res [3];
  logic [3:0]  nz [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunked_add_sub_unit #(.WIDTH(64), .CHUNK(16)) u16 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[0]), .in_ready(irdy[0]),
    .op(op), .carry_in(carry_in), .set_flags(set_flags),
    .a(a), .b(b),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .result(res[0]), .nzcv(nz[0]), .flags_valid(fv[0])
  );

  chunked_add_sub_unit #(.WIDTH(64), .CHUNK(64)) u64 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[1]), .in_ready(irdy[1]),
    .op(op), .carry_in(carry_in), .set_flags(set_flags),
    .a(a), .b(b),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .result(res[1]), .nzcv(nz[1]), .flags_valid(fv[1])
  );

  chunked_add_sub_unit #(.WIDTH(64), .CHUNK(8)) u8 (
    .clk(clk), .reset_n(reset_n),
    .in_valid(iv[2]), .in_ready(irdy[2]),
    .op(op), .carry_in(carry_in), .set_flags(set_flags),
    .a(a), .b(b),
    .out_valid(ov[2]), .out_ready(ordy[2]),
    .result(res[2]), .nzcv(nz[2]), .flags_valid(fv[2])
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic do_op(input int sel,
                       input logic [1:0] o,
                       input logic ci,
                       input logic sf,
                       input logic [63:0] av,
                       input logic [63:0] bv,
                       input logic [63:0] er,
                       input logic [3:0] en,
                       input logic efv,
                       input int elat,
                       input int hold,
                       input bit pulse);
    int n;
    @(negedge clk);
    chk("in_ready_idle", 64'(irdy[sel]), 64'd1);
    op        = o;
    carry_in  = ci;
    set_flags = sf;
    a         = av;
    b         = bv;
    iv[sel]   = 1'b1;
    @(negedge clk);
    iv[sel] = 1'b0;
    n = 0;
    while (!ov[sel] && n < 200) begin
      n++;
      if (pulse && n == 1) begin
        iv[sel]  = 1'b1;
        a        = ~av;
        b        = 64'd0;
        op       = ~o;
        carry_in = ~ci;
      end else begin
        iv[sel] = 1'b0;
      end
      @(negedge clk);
    end
    iv[sel] = 1'b0;
    chk("busy_cycles", 64'(n), 64'(elat));
    chk("result", res[sel], er);
    chk("nzcv", 64'(nz[sel]), 64'(en));
    chk("flags_valid", 64'(fv[sel]), 64'(efv));
    chk("in_ready_done", 64'(irdy[sel]), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(ov[sel]), 64'd1);
      chk("hold_result", res[sel], er);
      chk("hold_nzcv", 64'(nz[sel]), 64'(en));
      chk("hold_fv", 64'(fv[sel]), 64'(efv));
      chk("hold_in_ready", 64'(irdy[sel]), 64'd0);
    end
    ordy[sel] = 1'b1;
    @(negedge clk);
    ordy[sel] = 1'b0;
    chk("drained_out_valid", 64'(ov[sel]), 64'd0);
    chk("drained_in_ready", 64'(irdy[sel]), 64'd1);
  endtask

  initial begin
    reset_n   = 1'b0;
    iv        = 3'b000;
    ordy      = 3'b000;
    op        = 2'b00;
    carry_in  = 1'b0;
    set_flags = 1'b0;
    a         = 64'd0;
    b         = 64'd0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 64'(irdy), 64'h7);
    chk("rst_out_valid", 64'(ov), 64'h0);
    chk("rst_fv", 64'(fv), 64'h0);
    chk("rst_result", res[0], 64'd0);
    chk("rst_nzcv", 64'(nz[0]), 64'd0);
    reset_n = 1'b1;

    do_op(0, 2'b01, 1'b0, 1'b1, 64'd5, 64'd3,
          64'd2, 4'b0010, 1'b1, 4, 0, 0);
    do_op(0, 2'b01, 1'b0, 1'b1, 64'd3, 64'd5,
          64'hFFFF_FFFF_FFFF_FFFE, 4'b1000, 1'b1, 4, 0, 0);
    do_op(0, 2'b00, 1'b0, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
          64'd0, 4'b0110, 1'b1, 4, 0, 0);
    do_op(0, 2'b00, 1'b0, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
          64'h8000_0000_0000_0000, 4'b1001, 1'b1, 4, 0, 0);
    do_op(0, 2'b11, 1'b0, 1'b0, 64'd10, 64'd3,
          64'd6, 4'b0000, 1'b0, 4, 0, 0);
    do_op(0, 2'b10, 1'b1, 1'b0, 64'd10, 64'd3,
          64'd14, 4'b0000, 1'b0, 4, 0, 0);
    do_op(0, 2'b01, 1'b0, 1'b0, 64'd9, 64'd4,
          64'd5, 4'b0000, 1'b0, 4, 0, 0);
    do_op(0, 2'b01, 1'b0, 1'b1, 64'd5, 64'd3,
          64'd2, 4'b0010, 1'b1, 4, 10, 1);

    // Abort in the second BUSY cycle, then a clean request.
    @(negedge clk);
    op        = 2'b01;
    set_flags = 1'b1;
    a         = 64'd100;
    b         = 64'd1;
    iv[0]     = 1'b1;
    @(negedge clk);
    iv[0] = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(ov[0]), 64'd0);
    chk("abort_in_ready", 64'(irdy[0]), 64'd1);
    chk("abort_result", res[0], 64'd0);
    chk("abort_nzcv", 64'(nz[0]), 64'd0);
    chk("abort_fv", 64'(fv[0]), 64'd0);
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(ov[0]), 64'd0);
    end
    reset_n = 1'b1;
    do_op(0, 2'b01, 1'b0, 1'b1, 64'd100, 64'd1,
          64'd99, 4'b0010, 1'b1, 4, 0, 0);

    do_op(1, 2'b01, 1'b0, 1'b1, 64'd5, 64'd3,
          64'd2, 4'b0010, 1'b1, 1, 0, 0);
    do_op(2, 2'b01, 1'b0, 1'b1, 64'd5, 64'd3,
          64'd2, 4'b0010, 1'b1, 8, 0, 0);
    do_op(2, 2'b00, 1'b0, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
          64'd0, 4'b0110, 1'b1, 8, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
